// File: rtl/oursring_req_rr_arbiter.sv
// N-to-1 request-channel arbiter for oursring master ports: AW+W and AR are granted independently,
// with burst-locked W, grant held through downstream stalls, and a long-burst error pulse.
module oursring_req_rr_arbiter #(
    parameter int N_IN_PORT = 3,
    parameter int RR_EN     = 1,
    parameter int MAX_BURST = 256,
    parameter int SELW      = $clog2(N_IN_PORT)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_IN_PORT-1:0] i_awvalid,
    input  logic [N_IN_PORT-1:0] i_wvalid,
    input  logic [N_IN_PORT-1:0] i_wlast,
    input  logic [N_IN_PORT-1:0] i_arvalid,
    output logic [N_IN_PORT-1:0] i_awready,
    output logic [N_IN_PORT-1:0] i_wready,
    output logic [N_IN_PORT-1:0] i_arready,
    output logic                 o_awvalid,
    output logic                 o_wvalid,
    output logic                 o_arvalid,
    input  logic                 o_awready,
    input  logic                 o_wready,
    input  logic                 o_arready,
    output logic [SELW-1:0]      o_w_sel,
    output logic [SELW-1:0]      o_ar_sel,
    output logic                 o_burst_err
);

    // state   | meaning
    // W_IDLE  | arbitrating AW+W; first beat travels with the AW handshake
    // W_BURST | W locked to hold_idx until the beat carrying wlast

    localparam int                   CNTW    = $clog2(MAX_BURST + 1);
    localparam logic [N_IN_PORT-1:0] ONE_HOT = N_IN_PORT'(1);
    localparam logic [CNTW-1:0]      CNT_MAX = CNTW'(MAX_BURST);

    typedef enum logic {W_IDLE, W_BURST} w_state_t;

    w_state_t        w_state, w_state_nxt;
    logic [SELW-1:0] aw_ptr, ar_ptr, hold_idx, aw_lock_idx, ar_lock_idx;
    logic            aw_lock, ar_lock;
    logic [CNTW-1:0] beat_cnt, beat_cnt_nxt;

    logic [N_IN_PORT-1:0] aw_cand;
    logic [SELW-1:0]      aw_pick, aw_grant, ar_pick, ar_grant;
    logic                 aw_hs, ar_hs, w_beat, w_last;

    function automatic logic [SELW-1:0] rr_pick(input logic [N_IN_PORT-1:0] req,
                                                input logic [SELW-1:0]      ptr);
        logic [SELW-1:0] sel;
        logic            found;
        int              idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N_IN_PORT; k++) begin
            idx = (int'(ptr) + k) % N_IN_PORT;
            if (!found && req[idx[SELW-1:0]]) begin
                found = 1'b1;
                sel   = idx[SELW-1:0];
            end
        end
        return sel;
    endfunction

    function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] g);
        return (g == SELW'(N_IN_PORT - 1)) ? '0 : g + 1'b1;
    endfunction

    assign aw_cand  = i_awvalid & i_wvalid;
    assign aw_pick  = rr_pick(aw_cand, aw_ptr);
    assign aw_grant = aw_lock ? aw_lock_idx : aw_pick;
    assign ar_pick  = rr_pick(i_arvalid, ar_ptr);
    assign ar_grant = ar_lock ? ar_lock_idx : ar_pick;

    // Valids are gated by rstn so every ready drops the moment reset asserts.
    assign o_arvalid = rstn & (|i_arvalid);
    assign ar_hs     = o_arvalid & o_arready;
    assign i_arready = ar_hs ? (ONE_HOT << ar_grant) : '0;
    assign o_ar_sel  = ar_grant;

    always_comb begin
        w_state_nxt  = w_state;
        beat_cnt_nxt = beat_cnt;
        o_awvalid    = 1'b0;
        o_wvalid     = 1'b0;
        i_awready    = '0;
        i_wready     = '0;
        o_w_sel      = aw_grant;
        aw_hs        = 1'b0;
        w_beat       = 1'b0;
        w_last       = 1'b0;
        case (w_state)
            W_IDLE: begin
                o_awvalid = rstn & (|aw_cand);
                o_wvalid  = o_awvalid;
                aw_hs     = o_awvalid & o_awready & o_wready;
                w_beat    = aw_hs;
                w_last    = i_wlast[aw_grant];
                if (aw_hs) begin
                    i_awready = ONE_HOT << aw_grant;
                    i_wready  = ONE_HOT << aw_grant;
                    if (!w_last) begin
                        w_state_nxt  = W_BURST;
                        beat_cnt_nxt = CNTW'(1);
                    end
                end
            end
            W_BURST: begin
                o_w_sel  = hold_idx;
                o_wvalid = rstn & i_wvalid[hold_idx];
                w_beat   = o_wvalid & o_wready;
                w_last   = i_wlast[hold_idx];
                i_wready = w_beat ? (ONE_HOT << hold_idx) : '0;
                if (w_beat) begin
                    if (w_last) begin
                        w_state_nxt  = W_IDLE;
                        beat_cnt_nxt = '0;
                    end else if (beat_cnt != CNT_MAX) begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
        // Fires only on the transition into the saturated count, so once per burst.
        o_burst_err = w_beat & ~w_last & (beat_cnt_nxt == CNT_MAX) & (beat_cnt != CNT_MAX);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state     <= W_IDLE;
            beat_cnt    <= '0;
            hold_idx    <= '0;
            aw_ptr      <= '0;
            ar_ptr      <= '0;
            aw_lock     <= 1'b0;
            ar_lock     <= 1'b0;
            aw_lock_idx <= '0;
            ar_lock_idx <= '0;
        end else begin
            w_state  <= w_state_nxt;
            beat_cnt <= beat_cnt_nxt;
            if (aw_hs) begin
                hold_idx <= aw_grant;
                aw_lock  <= 1'b0;
                if (RR_EN != 0) aw_ptr <= next_idx(aw_grant);
            end else if (o_awvalid) begin
                aw_lock     <= 1'b1;
                aw_lock_idx <= aw_grant;
            end
            if (ar_hs) begin
                ar_lock <= 1'b0;
                if (RR_EN != 0) ar_ptr <= next_idx(ar_grant);
            end else if (o_arvalid) begin
                ar_lock     <= 1'b1;
                ar_lock_idx <= ar_grant;
            end
        end
    end

endmodule

// File: tb/tb_oursring_req_rr_arbiter.sv
// Randomised scoreboard bench: a round-robin and a fixed-priority arbiter run side by side,
// each against a transaction-level model of its upstream masters and grant rules.
module tb_oursring_req_rr_arbiter;
    localparam int N    = 3;
    localparam int MAXB = 4;
    localparam int SW   = 2;
    localparam int NCYC = 3000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]  awv[2], wv[2], wl[2], arv[2], awr[2], wr[2], arr[2];
    logic          o_awv[2], o_wv[2], o_arv[2], dn_awr[2], dn_wr[2], dn_arr[2], berr[2];
    logic [SW-1:0] wsel[2], arsel[2];

    oursring_req_rr_arbiter #(.N_IN_PORT(N), .RR_EN(1), .MAX_BURST(MAXB)) u_rr (
        .clk(clk), .rstn(rstn),
        .i_awvalid(awv[0]), .i_wvalid(wv[0]), .i_wlast(wl[0]), .i_arvalid(arv[0]),
        .i_awready(awr[0]), .i_wready(wr[0]), .i_arready(arr[0]),
        .o_awvalid(o_awv[0]), .o_wvalid(o_wv[0]), .o_arvalid(o_arv[0]),
        .o_awready(dn_awr[0]), .o_wready(dn_wr[0]), .o_arready(dn_arr[0]),
        .o_w_sel(wsel[0]), .o_ar_sel(arsel[0]), .o_burst_err(berr[0])
    );

    oursring_req_rr_arbiter #(.N_IN_PORT(N), .RR_EN(0), .MAX_BURST(MAXB)) u_fp (
        .clk(clk), .rstn(rstn),
        .i_awvalid(awv[1]), .i_wvalid(wv[1]), .i_wlast(wl[1]), .i_arvalid(arv[1]),
        .i_awready(awr[1]), .i_wready(wr[1]), .i_arready(arr[1]),
        .o_awvalid(o_awv[1]), .o_wvalid(o_wv[1]), .o_arvalid(o_arv[1]),
        .o_awready(dn_awr[1]), .o_wready(dn_wr[1]), .o_arready(dn_arr[1]),
        .o_w_sel(wsel[1]), .o_ar_sel(arsel[1]), .o_burst_err(berr[1])
    );

    typedef struct {
        int inst;
        int ch;
        int port;
        bit aw;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    // transaction-level view of each bench: masters, current W owner, priority pointers
    int owner[2], wbeats[2], awptr[2], awlock[2], arptr[2], arlock[2];
    bit pend_aw[2][N], w_on[2][N], in_burst[2][N], ar_on[2][N];
    int beats_left[2][N];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit [N-1:0] c, input int ptr);
        for (int k = 0; k < N; k++)
            if (c[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            owner[i] = -1; wbeats[i] = 0; awptr[i] = 0; awlock[i] = -1;
            arptr[i] = 0; arlock[i] = -1;
            dn_awr[i] = 1'b0; dn_wr[i] = 1'b0; dn_arr[i] = 1'b0;
            for (int p = 0; p < N; p++) begin
                pend_aw[i][p] = 1'b0; w_on[i][p] = 1'b0; in_burst[i][p] = 1'b0;
                ar_on[i][p] = 1'b0; beats_left[i][p] = 0;
            end
        end
    endtask

    task automatic drive_pins();
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < N; p++) begin
                awv[i][p] = pend_aw[i][p];
                wv[i][p]  = pend_aw[i][p] | w_on[i][p];
                wl[i][p]  = (beats_left[i][p] == 1);
                arv[i][p] = ar_on[i][p];
            end
    endtask

    // First 8 cycles: every port offers single-beat writes with downstream always ready.
    task automatic gen(input int cyc);
        bit directed;
        directed = (cyc < 8);
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < N; p++) begin
                if (!pend_aw[i][p] && !in_burst[i][p] && (directed || $urandom_range(99) < 30)) begin
                    pend_aw[i][p]    = 1'b1;
                    beats_left[i][p] = directed ? 1 : int'($urandom_range(1, 7));
                end
                if (in_burst[i][p] && !w_on[i][p] && $urandom_range(99) < 60) w_on[i][p] = 1'b1;
                if (!directed && !ar_on[i][p] && $urandom_range(99) < 35) ar_on[i][p] = 1'b1;
            end
            dn_awr[i] = directed || ($urandom_range(99) < 70);
            dn_wr[i]  = directed || ($urandom_range(99) < 70);
            dn_arr[i] = directed || ($urandom_range(99) < 70);
        end
    endtask

    task automatic step(input int i);
        bit [N-1:0] cand;
        int   g, beats;
        bit   v, hs, last;
        exp_t e;
        for (int p = 0; p < N; p++) cand[p] = pend_aw[i][p];
        if (owner[i] >= 0) begin
            g  = owner[i];
            v  = w_on[i][g];
            hs = v && dn_wr[i];
        end else begin
            g  = (awlock[i] >= 0) ? awlock[i] : pick(cand, awptr[i]);
            v  = (cand != 0);
            hs = v && dn_awr[i] && dn_wr[i];
            if (v && !hs) awlock[i] = g;
        end
        if (hs) begin
            last  = (beats_left[i][g] == 1);
            beats = (owner[i] < 0) ? 1 : wbeats[i] + 1;
            e.inst = i; e.ch = 0; e.port = g; e.aw = (owner[i] < 0); e.err = !last && (beats == MAXB);
            sb.push_back(e);
            if (owner[i] < 0) begin
                awlock[i] = -1;
                if (i == 0) awptr[i] = (g + 1) % N;
                pend_aw[i][g] = 1'b0;
            end else begin
                w_on[i][g] = 1'b0;
            end
            beats_left[i][g]--;
            if (last) begin
                owner[i] = -1; in_burst[i][g] = 1'b0;
            end else begin
                owner[i] = g; in_burst[i][g] = 1'b1; wbeats[i] = beats;
            end
        end
        for (int p = 0; p < N; p++) cand[p] = ar_on[i][p];
        if (cand != 0) begin
            g = (arlock[i] >= 0) ? arlock[i] : pick(cand, arptr[i]);
            if (dn_arr[i]) begin
                e.inst = i; e.ch = 1; e.port = g; e.aw = 1'b0; e.err = 1'b0;
                sb.push_back(e);
                arlock[i] = -1;
                if (i == 0) arptr[i] = (g + 1) % N;
                ar_on[i][g] = 1'b0;
            end else begin
                arlock[i] = g;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rstn && mon_en) begin
                for (int i = 0; i < 2; i++) begin
                    exp_t e;
                    chk("ready_onehot", int'($onehot0(awr[i]) && $onehot0(wr[i]) && $onehot0(arr[i])), 1);
                    if (o_wv[i] && dn_wr[i] && (!o_awv[i] || dn_awr[i])) begin
                        if (sb.size() == 0) chk("w_unexpected", 1, 0);
                        else begin
                            e = sb.pop_front();
                            chk("w_tag", e.inst * 2 + e.ch, i * 2);
                            chk("w_ready", int'(wr[i]), 1 << e.port);
                            chk("w_sel", int'(wsel[i]), e.port);
                            chk("aw_ready", int'(awr[i]), e.aw ? (1 << e.port) : 0);
                            chk("aw_valid", int'(o_awv[i]), int'(e.aw));
                            chk("burst_err", int'(berr[i]), int'(e.err));
                        end
                    end else begin
                        chk("burst_err_idle", int'(berr[i]), 0);
                        chk("aw_ready_idle", int'(awr[i]), 0);
                    end
                    if (o_arv[i] && dn_arr[i]) begin
                        if (sb.size() == 0) chk("ar_unexpected", 1, 0);
                        else begin
                            e = sb.pop_front();
                            chk("ar_tag", e.inst * 2 + e.ch, i * 2 + 1);
                            chk("ar_ready", int'(arr[i]), 1 << e.port);
                            chk("ar_sel", int'(arsel[i]), e.port);
                        end
                    end else begin
                        chk("ar_ready_idle", int'(arr[i]), 0);
                    end
                end
                chk("sb_drain", sb.size(), 0);
                sb.delete();
            end
        end
    end

    initial begin
        bit rst_done;
        rst_done = 1'b0;
        reset_model();
        drive_pins();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        mon_en = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            if (!rst_done && cyc > 200 && owner[0] >= 0 && wbeats[0] == 1) begin
                rstn = 1'b0;
                #1;
                for (int i = 0; i < 2; i++) begin
                    chk("rst_readies", int'({awr[i], wr[i], arr[i]}), 0);
                    chk("rst_valids", int'({o_awv[i], o_wv[i], o_arv[i]}), 0);
                end
                reset_model();
                drive_pins();
                sb.delete();
                @(negedge clk);
                #2 rstn = 1'b1;
                rst_done = 1'b1;
            end else begin
                gen(cyc);
                drive_pins();
                step(0);
                step(1);
            end
        end
        @(posedge clk);
        #1;
        reset_model();
        drive_pins();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_exercised", int'(rst_done), 1);
        chk("sb_final", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
